// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and helpers for the score seven-segment display
// Contents: converter FSM state enum, score ceiling, active-low segment code table,
// blank code, and the digit decode / saturation helpers used by the block.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } conv_state_t;

  localparam logic [13:0] MAX_SCORE = 14'd9999;

  // Double-dabble runs one iteration per input bit.
  localparam logic [3:0] LAST_ITER = 4'd13;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry d is the code for decimal digit d.
  localparam logic [9:0][6:0] SEG_CODES = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return SEG_CODES[digit];
    end
    return SEG_OFF;
  endfunction

  function automatic logic [13:0] saturate(input logic [13:0] value);
    return (value > MAX_SCORE) ? MAX_SCORE : value;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - handshaked sequential binary-to-BCD converter (shift-add-3)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   score_in    : 14-bit binary score, saturated to 9999 on capture
//   score_vld   : score_in valid, held by upstream until accepted
//   score_rdy   : high only in IDLE
//   bcd         : 16-bit BCD result, meaningful while commit is high
//   commit      : one-cycle strobe marking the finished result
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] score_in,
  input  logic        score_vld,
  output logic        score_rdy,
  output logic [15:0] bcd,
  output logic        commit
);

  conv_state_t state_q, state_d;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  iter_q;
  logic [15:0] bcd_adj;

  // Pre-shift correction: any nibble that would reach 10 after doubling gets +3.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    score_rdy = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        score_rdy = 1'b1;
        if (score_vld) begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (iter_q == LAST_ITER) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else begin
      if (state_q == ST_IDLE && score_vld) begin
        bin_q  <= saturate(score_in);
        bcd_q  <= '0;
        iter_q <= '0;
      end else if (state_q == ST_CONVERT) begin
        {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
        iter_q         <= iter_q + 4'd1;
      end
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/score_seg_display.sv
// rtl/score_seg_display.sv - 4-digit multiplexed seven-segment score display
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   score_in    : 14-bit binary score (values above 9999 show as 9999)
//   score_vld   : score_in valid, held until accepted
//   score_rdy   : block can accept a score
//   an          : active-low digit anodes, an[0] = rightmost digit
//   seg         : active-low segments {g,f,e,d,c,b,a}
//   dp          : active-low decimal point, always off
module score_seg_display
  import seg_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] score_in,
  input  logic        score_vld,
  output logic        score_rdy,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIV_RAW = CLK_HZ / SCAN_HZ;
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int PW      = $clog2(DIV);

  logic [15:0]   bcd;
  logic          commit;
  logic [15:0]   disp_q;
  logic [PW-1:0] pre_q;
  logic [1:0]    idx_q;
  logic [1:0]    idx_n;
  logic          wrap;
  logic          blank;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          z3, z32, z321;

  bin2bcd_seq u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .score_in  (score_in),
    .score_vld (score_vld),
    .score_rdy (score_rdy),
    .bcd       (bcd),
    .commit    (commit)
  );

  assign wrap  = (pre_q == PW'(DIV - 1));
  assign idx_n = idx_q + 2'd1;

  // Zero runs from the most significant digit downward decide blanking.
  assign z3   = (disp_q[15:12] == 4'd0);
  assign z32  = z3  && (disp_q[11:8] == 4'd0);
  assign z321 = z32 && (disp_q[7:4]  == 4'd0);

  // Outputs are precomputed for the slot about to start, so they land on the wrap edge.
  always_comb begin
    blank = 1'b0;
    unique case (idx_n)
      2'd1:    blank = z321;
      2'd2:    blank = z32;
      2'd3:    blank = z3;
      default: blank = 1'b0;
    endcase
    seg_d = seg_decode(disp_q[{idx_n, 2'b00} +: 4]);
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      pre_q  <= '0;
      idx_q  <= '0;
      an     <= 4'b1110;
      seg    <= SEG_CODES[0];
    end else begin
      if (commit) begin
        disp_q <= bcd;
      end
      if (wrap) begin
        pre_q <= '0;
        idx_q <= idx_n;
        an    <= an_d;
        seg   <= seg_d;
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_score_seg_display.sv
// tb/tb_score_seg_display.sv - self-checking bench for score_seg_display
module tb_score_seg_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] score_in = '0;
  logic        score_vld = 1'b0;
  logic        score_rdy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int cmp_total = 0;
  int cmp_fail  = 0;

  always #5 clk = ~clk;

  score_seg_display #(.CLK_HZ(400), .SCAN_HZ(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .score_in  (score_in),
    .score_vld (score_vld),
    .score_rdy (score_rdy),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pow10(input int k);
    case (k)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    cmp_total++;
    if (act != exp) begin
      cmp_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: score shown = decimal value committed 15 edges after acceptance;
  // each slot of DIV edges shows digit (n/DIV)%4 of the value current at its start.
  int n, m_idx, m_val, m_disp, m_rem, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n      <= 0;
      m_idx  <= 0;
      m_val  <= 0;
      m_disp <= 0;
      m_rem  <= 0;
      m_pend <= 0;
    end else begin
      n <= n + 1;
      if ((n + 1) % DIV == 0) begin
        m_idx <= ((n + 1) / DIV) % 4;
        m_val <= m_disp;
      end
      if (m_rem == 0) begin
        if (score_vld) begin
          m_rem  <= 15;
          m_pend <= (int'(score_in) > 9999) ? 9999 : int'(score_in);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_disp <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       er;
    ea = 4'b0001 << m_idx;
    ea = ~ea;
    if (m_idx > 0 && m_val < pow10(m_idx)) ea = 4'b1111;
    es = seg_of((m_val / pow10(m_idx)) % 10);
    er = (m_rem == 0);
    chk("scan", int'({an, seg, dp, score_rdy}), int'({ea, es, 1'b1, er}));
  end

  task automatic check_slot(input int idx, input logic [3:0] ea, input logic [6:0] es,
                            input string nm);
    int k = 0;
    while (m_idx == idx && k < 40) begin @(negedge clk); k++; end
    while (m_idx != idx && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) begin
      cmp_total++;
      cmp_fail++;
      $display("FAIL %s: slot %0d not reached, got timeout expected slot", nm, idx);
    end else begin
      chk({nm, "_an"}, int'(an), int'(ea));
      chk({nm, "_seg"}, int'(seg), int'(es));
    end
  endtask

  task automatic wait_rdy(input string nm);
    int k = 0;
    @(negedge clk);
    while (!score_rdy && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) begin
      cmp_total++;
      cmp_fail++;
      $display("FAIL %s: score_rdy got 0 expected 1 within 40 cycles", nm);
    end
  endtask

  task automatic send(input int value, input string nm);
    int low = 0;
    wait_rdy(nm);
    score_in  = 14'(value);
    score_vld = 1'b1;
    @(posedge clk);
    #1 score_vld = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (score_rdy) break;
      low++;
    end
    chk({nm, "_rdy_low"}, low, 15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // 1: reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_an", int'(an), 4'b1110);
    chk("rst_seg", int'(seg), 7'b1000000);
    chk("rst_dp", int'(dp), 1);
    chk("rst_rdy", int'(score_rdy), 1);
    check_slot(1, 4'b1111, 7'b1000000, "rst_slot1");
    check_slot(2, 4'b1111, 7'b1000000, "rst_slot2");
    check_slot(0, 4'b1110, 7'b1000000, "rst_slot0");

    // 2: single conversion
    send(1234, "c1234");
    check_slot(0, 4'b1110, 7'b0011001, "c1234_d0");
    check_slot(1, 4'b1101, 7'b0110000, "c1234_d1");
    check_slot(2, 4'b1011, 7'b0100100, "c1234_d2");
    check_slot(3, 4'b0111, 7'b1111001, "c1234_d3");

    // 3: saturation
    send(16383, "sat");
    check_slot(0, 4'b1110, 7'b0010000, "sat_d0");
    check_slot(1, 4'b1101, 7'b0010000, "sat_d1");
    check_slot(2, 4'b1011, 7'b0010000, "sat_d2");
    check_slot(3, 4'b0111, 7'b0010000, "sat_d3");

    // 4: blanking
    send(70, "blk");
    check_slot(0, 4'b1110, 7'b1000000, "blk_d0");
    check_slot(1, 4'b1101, 7'b1111000, "blk_d1");
    check_slot(2, 4'b1111, 7'b1000000, "blk_d2");
    check_slot(3, 4'b1111, 7'b1000000, "blk_d3");

    // 5: busy hold, value changes while converting
    wait_rdy("busy");
    score_in  = 14'd5;
    score_vld = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 score_in = 14'd42;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("busy_rdy_t14", int'(score_rdy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("busy_rdy_t15", int'(score_rdy), 1);
    @(posedge clk);
    #1 score_vld = 1'b0;
    @(negedge clk);
    chk("busy_rdy_t16", int'(score_rdy), 0);
    wait_rdy("busy2");
    check_slot(0, 4'b1110, 7'b0100100, "busy_d0");
    check_slot(1, 4'b1101, 7'b0011001, "busy_d1");
    check_slot(2, 4'b1111, 7'b1000000, "busy_d2");

    // 6: reset during conversion
    wait_rdy("mid");
    score_in  = 14'd888;
    score_vld = 1'b1;
    @(posedge clk);
    #1 score_vld = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_an", int'(an), 4'b1110);
    chk("mid_seg", int'(seg), 7'b1000000);
    chk("mid_dp", int'(dp), 1);
    chk("mid_rdy", int'(score_rdy), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_slot(1, 4'b1111, 7'b1000000, "mid_d1");
    check_slot(0, 4'b1110, 7'b1000000, "mid_d0");
    repeat (20) @(negedge clk);
    check_slot(0, 4'b1110, 7'b1000000, "mid_d0_late");
    chk("mid_rdy_late", int'(score_rdy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
    $finish;
  end

endmodule
